// File: rtl/game_referee.sv
// game_referee: round controller sitting after the player2 guess stage.
// Sequences IDLE -> ARMED -> PLAYING -> WON/LOST, and tracks lives, the
// inactivity timer, the attempt count and a saturating score.
module game_referee #(
  parameter int MAX_LIVES      = 3,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TIMER_W        = 26,
  parameter int SCORE_W        = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               p1_ready,
  input  logic [1:0]         correct,
  input  logic               complete,
  input  logic               read,
  output logic               p2_enable,
  output logic [2:0]         state,
  output logic [2:0]         lives,
  output logic [7:0]         attempts,
  output logic [SCORE_W-1:0] score,
  output logic               timeout,
  output logic               win,
  output logic               lose,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_ARMED   = 3'b001,
    S_PLAYING = 3'b010,
    S_WON     = 3'b011,
    S_LOST    = 3'b100
  } state_e;

  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam logic [2:0]         LIVES_INIT   = 3'(MAX_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX    = {SCORE_W{1'b1}};

  localparam logic [1:0] V_NEUTRAL   = 2'b00;
  localparam logic [1:0] V_CORRECT   = 2'b01;
  localparam logic [1:0] V_INCORRECT = 2'b10;
  localparam logic [1:0] V_ILLEGAL   = 2'b11;

  state_e               state_q;
  logic [2:0]           lives_q;
  logic [7:0]           attempts_q;
  logic [SCORE_W-1:0]   score_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 prev_complete_q;
  logic                 timeout_q;
  logic                 win_q;
  logic                 lose_q;
  logic                 err_q;
  logic                 p2_enable_q;
  logic [SCORE_W-1:0]   score_win_d;

  // Saturating score update: score + 1 + remaining lives, clamped at all-ones.
  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s,
                                                   input logic [2:0] l);
    logic [SCORE_W+3:0] sum;
    sum = {4'b0000, s} + {{(SCORE_W+1){1'b0}}, l} + (SCORE_W+4)'(1);
    if (sum > {4'b0000, SCORE_MAX}) begin
      return SCORE_MAX;
    end else begin
      return sum[SCORE_W-1:0];
    end
  endfunction

  // Score that a win on this cycle would commit.
  always_comb begin
    score_win_d = sat_score(score_q, lives_q);
  end

  // Round FSM together with lives, timer, attempts, score and status flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      lives_q         <= 3'd0;
      attempts_q      <= 8'd0;
      score_q         <= {SCORE_W{1'b0}};
      timer_q         <= {TIMER_W{1'b0}};
      prev_complete_q <= 1'b0;
      timeout_q       <= 1'b0;
      win_q           <= 1'b0;
      lose_q          <= 1'b0;
      err_q           <= 1'b0;
      p2_enable_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_ARMED;
            lives_q    <= LIVES_INIT;
            attempts_q <= 8'd0;
          end
        end
        S_ARMED: begin
          if (p1_ready) begin
            state_q         <= S_PLAYING;
            timer_q         <= TIMER_RELOAD;
            prev_complete_q <= 1'b0;
            p2_enable_q     <= 1'b1;
          end
        end
        S_PLAYING: begin
          // Two consecutive high samples of complete are needed for a win.
          prev_complete_q <= complete;
          if (correct == V_ILLEGAL) begin
            err_q <= 1'b1;
          end
          if (read && (attempts_q != 8'hFF)) begin
            attempts_q <= attempts_q + 8'd1;
          end
          if (complete && prev_complete_q) begin
            state_q     <= S_WON;
            score_q     <= score_win_d;
            win_q       <= 1'b1;
            p2_enable_q <= 1'b0;
          end else if ((correct == V_INCORRECT) || (timer_q == {TIMER_W{1'b0}})) begin
            // A simultaneous INCORRECT and expiry costs only one life.
            timer_q   <= TIMER_RELOAD;
            timeout_q <= (timer_q == {TIMER_W{1'b0}});
            if (lives_q <= 3'd1) begin
              lives_q     <= 3'd0;
              state_q     <= S_LOST;
              lose_q      <= 1'b1;
              p2_enable_q <= 1'b0;
            end else begin
              lives_q <= lives_q - 3'd1;
            end
          end else if (correct == V_CORRECT) begin
            timer_q <= TIMER_RELOAD;
          end else begin
            // NEUTRAL, and the illegal code treated as NEUTRAL.
            timer_q <= timer_q - TIMER_ONE;
          end
        end
        S_WON, S_LOST: begin
          if (start) begin
            state_q    <= S_ARMED;
            lives_q    <= LIVES_INIT;
            attempts_q <= 8'd0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          win_q       <= 1'b0;
          lose_q      <= 1'b0;
          p2_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign lives     = lives_q;
  assign attempts  = attempts_q;
  assign score     = score_q;
  assign timeout   = timeout_q;
  assign win       = win_q;
  assign lose      = lose_q;
  assign err       = err_q;
  assign p2_enable = p2_enable_q;

endmodule

// File: tb/tb_game_referee.sv
// Self-checking bench for game_referee: a round-level reference model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_game_referee;

  localparam int TO    = 20;
  localparam int MAXL  = 3;
  localparam int SW    = 8;
  localparam int SMAX  = 255;

  localparam int ST_IDLE = 0, ST_ARMED = 1, ST_PLAY = 2, ST_WON = 3, ST_LOST = 4;

  logic          clock;
  logic          resetn;
  logic          start;
  logic          p1_ready;
  logic [1:0]    correct;
  logic          complete;
  logic          read;
  logic          p2_enable;
  logic [2:0]    state;
  logic [2:0]    lives;
  logic [7:0]    attempts;
  logic [SW-1:0] score;
  logic          timeout;
  logic          win;
  logic          lose;
  logic          err;

  int n_vec = 0;
  int n_bad = 0;

  game_referee #(
    .MAX_LIVES(MAXL), .TIMEOUT_CYCLES(TO), .TIMER_W(26), .SCORE_W(SW)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .p1_ready(p1_ready),
    .correct(correct), .complete(complete), .read(read),
    .p2_enable(p2_enable), .state(state), .lives(lives), .attempts(attempts),
    .score(score), .timeout(timeout), .win(win), .lose(lose), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: rounds, lives, and "quiet" = consecutive PLAYING cycles
  // without a non-NEUTRAL verdict; the life is lost on the TO-th quiet cycle.
  int m_state, m_lives, m_att, m_score, m_quiet, m_streak;
  bit m_err, m_to;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_state = ST_IDLE; m_lives = 0; m_att = 0; m_score = 0;
      m_quiet = 0; m_streak = 0; m_err = 0; m_to = 0;
    end else begin
      m_to = 0;
      case (m_state)
        ST_IDLE, ST_WON, ST_LOST: begin
          if (start) begin m_state = ST_ARMED; m_lives = MAXL; m_att = 0; end
        end
        ST_ARMED: begin
          if (p1_ready) begin m_state = ST_PLAY; m_quiet = 0; m_streak = 0; end
        end
        ST_PLAY: begin
          if (correct == 2'd3) m_err = 1;
          if (read && m_att < 255) m_att = m_att + 1;
          m_streak = complete ? m_streak + 1 : 0;
          if (m_streak >= 2) begin
            m_state = ST_WON;
            m_score = (m_score + 1 + m_lives > SMAX) ? SMAX : m_score + 1 + m_lives;
          end else if (correct == 2'd2 || m_quiet == TO - 1) begin
            m_to = (m_quiet == TO - 1);
            m_quiet = 0;
            m_lives = m_lives - 1;
            if (m_lives == 0) m_state = ST_LOST;
          end else if (correct == 2'd1) begin
            m_quiet = 0;
          end else begin
            m_quiet = m_quiet + 1;
          end
        end
        default: m_state = ST_IDLE;
      endcase
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clock) begin
    logic [31:0] e_st, e_lv, e_at, e_sc;
    logic        e_p2, e_w, e_l, e_e, e_t;
    e_st = m_state; e_lv = m_lives; e_at = m_att; e_sc = m_score;
    e_p2 = (m_state == ST_PLAY); e_w = (m_state == ST_WON);
    e_l = (m_state == ST_LOST); e_e = m_err; e_t = m_to;
    n_vec++;
    if ({state, lives, attempts, score, p2_enable, win, lose, err, timeout} !==
        {e_st[2:0], e_lv[2:0], e_at[7:0], e_sc[SW-1:0], e_p2, e_w, e_l, e_e, e_t}) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t got st=%0d lv=%0d at=%0d sc=%0d p2=%b w=%b l=%b e=%b to=%b exp st=%0d lv=%0d at=%0d sc=%0d p2=%b w=%b l=%b e=%b to=%b",
               $time, state, lives, attempts, score, p2_enable, win, lose, err, timeout,
               e_st, e_lv, e_at, e_sc, e_p2, e_w, e_l, e_e, e_t);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge) and advance to the next negedge.
  task automatic cyc(input logic s, input logic p, input logic [1:0] c,
                     input logic cm, input logic r);
    start = s; p1_ready = p; correct = c; complete = cm; read = r;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic win_round(input int n_inc);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    repeat (n_inc) cyc(1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; p1_ready = 1'b0; correct = 2'd0;
    complete = 1'b0; read = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    check("reset_state", {29'd0, state}, 32'd0);
    check("reset_score", {24'd0, score}, 32'd0);

    // Three INCORRECT verdicts: 3 -> 2 -> 1 -> 0 and LOST.
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("armed", {29'd0, state}, 32'd1);
    cyc(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    check("playing_lives", {29'd0, lives}, 32'd3);
    check("playing_p2en", {31'd0, p2_enable}, 32'd1);
    cyc(1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    check("inc1_lives", {29'd0, lives}, 32'd2);
    cyc(1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    check("inc2_lives", {29'd0, lives}, 32'd1);
    cyc(1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    check("inc3_lives", {29'd0, lives}, 32'd0);
    check("inc3_state", {29'd0, state}, 32'd4);
    check("inc3_lose", {31'd0, lose}, 32'd1);
    check("inc3_p2en", {31'd0, p2_enable}, 32'd0);

    // Inactivity timeout on the 20th quiet cycle; LOST after 60.
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    idle(19);
    check("to19_timeout", {31'd0, timeout}, 32'd0);
    check("to19_lives", {29'd0, lives}, 32'd3);
    idle(1);
    check("to20_timeout", {31'd0, timeout}, 32'd1);
    check("to20_lives", {29'd0, lives}, 32'd2);
    idle(1);
    check("to21_timeout", {31'd0, timeout}, 32'd0);
    idle(39);
    check("to60_state", {29'd0, state}, 32'd4);

    // INCORRECT together with expiry: one life only, timer reloads to 19.
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    idle(19);
    cyc(1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    check("both_lives", {29'd0, lives}, 32'd2);
    check("both_timeout", {31'd0, timeout}, 32'd1);
    idle(19);
    check("reload_quiet", {31'd0, timeout}, 32'd0);
    idle(1);
    check("reload_expiry", {31'd0, timeout}, 32'd1);
    check("reload_lives", {29'd0, lives}, 32'd1);
    cyc(1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    check("reload_lost", {29'd0, state}, 32'd4);

    // Win filter: one-cycle complete is ignored; two cycles win.
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    check("glitch_nowin", {29'd0, state}, 32'd2);
    cyc(1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    check("win1_state", {29'd0, state}, 32'd3);
    check("win1_win", {31'd0, win}, 32'd1);
    check("win1_score", {24'd0, score}, 32'd3);
    win_round(0);
    check("win2_score", {24'd0, score}, 32'd7);

    // Drive score to 254 (61 wins at +4, one at +3), then saturate.
    repeat (61) win_round(0);
    win_round(1);
    check("score_254", {24'd0, score}, 32'd254);
    win_round(0);
    check("score_sat", {24'd0, score}, 32'd255);
    @(negedge clock); #2 resetn = 1'b0;
    #1 check("score_reset", {24'd0, score}, 32'd0);
    @(negedge clock); resetn = 1'b1;

    // Illegal verdict, read pulses, then reset mid-round.
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    check("err_set", {31'd0, err}, 32'd1);
    check("err_lives", {29'd0, lives}, 32'd3);
    idle(1);
    check("err_sticky", {31'd0, err}, 32'd1);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("start_ignored", {29'd0, state}, 32'd2);
    repeat (5) begin
      cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    end
    check("attempts5", {24'd0, attempts}, 32'd5);
    #2 resetn = 1'b0;
    #1;
    check("midreset_state", {29'd0, state}, 32'd0);
    check("midreset_outs", {16'd0, lives, attempts, p2_enable, win, lose, err, timeout},
          32'd0);
    @(negedge clock); resetn = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/game_referee.md
Name: game_referee

Overview:
- Round controller directly downstream of the player2 guess stage.
- Consumes the guess stage's per-cycle verdict (correct), code-match flag (complete) and reload pulse (read).
- Sequences a round: wait for start, wait for player1 to lock a code, play, then declare win or loss.
- Tracks lives, an inactivity timeout, attempts and a saturating score. Drives the enable for player2 and status for the display.

Parameters:
- MAX_LIVES, 3, lives loaded at round start; legal range 1..7.
- TIMEOUT_CYCLES, 50000000, cycles without a non-NEUTRAL verdict before a life is lost; benches use 20.
- TIMER_W, 26, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^TIMER_W.
- SCORE_W, 8, score width.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  synchronous pulse or level; starts or re-arms a round.
- p1_ready  in  1  high once player1 has locked its code.
- correct  in  2  verdict from player2: 00 NEUTRAL, 01 CORRECT, 10 INCORRECT, 11 illegal.
- complete  in  1  player2 value equals player1 value.
- read  in  1  one-cycle pulse when player2 reloads.
- p2_enable  out  1  high only in PLAYING.
- state  out  3  000 IDLE, 001 ARMED, 010 PLAYING, 011 WON, 100 LOST.
- lives  out  3  remaining lives.
- attempts  out  8  count of read pulses in the current round; saturates at 255.
- score  out  SCORE_W  accumulated score, saturating.
- timeout  out  1  one-cycle pulse on timer expiry.
- win  out  1  level, high in WON.
- lose  out  1  level, high in LOST.
- err  out  1  sticky; set when correct==11 is seen in PLAYING.

Behaviour:
- Reset (resetn low, asynchronous) forces:
  - state IDLE;
  - lives, attempts, score, timer and complete-filter all 0;
  - timeout, win, lose, err, p2_enable all 0.
- All other updates occur on the rising edge of clock. All outputs are registered.
- IDLE:
  - start=1 -> ARMED; lives<=MAX_LIVES; attempts<=0.
- ARMED:
  - p1_ready=1 -> PLAYING; timer<=TIMEOUT_CYCLES-1.
  - p1_ready is ignored in every other state.
- PLAYING, evaluated in priority order each cycle:
  1. Win: complete sampled high on two consecutive edges -> WON; score <= sat(score + 1 + lives).
     - The two-sample filter masks the clock-qualified glitch on complete.
     - Win beats any simultaneous INCORRECT or timeout.
  2. Life loss: correct==10, or timer==0, or both in the same cycle -> lives decrements by exactly 1.
     - timer reloads to TIMEOUT_CYCLES-1.
     - timeout pulses only if timer==0 caused it.
     - If lives was 1 -> LOST, lives=0.
  3. correct==01 -> timer reloads.
  4. correct==00 -> timer decrements.
  5. correct==11 -> treated as 00; err<=1.
- read=1 in PLAYING -> attempts increments, saturating; this is independent of the priority chain above.
- Win-filter: a 1-bit register holding the previous sample of complete, cleared on every PLAYING entry.
- WON / LOST:
  - Outputs hold; p2_enable=0.
  - start=1 -> ARMED; lives<=MAX_LIVES; attempts<=0; score retained.
- Illegal state encodings (101..111) -> IDLE on the next edge.
- Latency:
  - A verdict at edge N is reflected in lives/state after edge N.
  - A win is declared on the edge of the second consecutive high sample of complete.
- Score:
  - Unsigned; addition saturates at 2^SCORE_W-1.
  - Cleared only by resetn.
- Reset mid-round: returns to IDLE immediately, with no win/lose pulse.
- start while in ARMED or PLAYING is ignored.

Test Plan (TIMEOUT_CYCLES=20, MAX_LIVES=3):
- Reset then start, p1_ready, and three INCORRECT verdicts on separate cycles -> lives 3,2,1,0; state LOST after the third; lose=1; p2_enable=0.
- Enter PLAYING with correct held 00 for 20 cycles -> timeout pulses on cycle 20 and lives=2; after 60 idle cycles -> LOST.
- INCORRECT on the same cycle the timer hits 0 -> lives drops by 1 only; timeout=1; timer reloads to 19.
- complete high for exactly 1 cycle -> no win; complete high for 2 cycles with lives=2 -> WON, score=3; a second round won with lives=3 -> score=7.
- Score preloaded near saturation (SCORE_W=8, score=254), then a win with lives=3 -> score=255; reset -> score=0.
- correct=11 during PLAYING -> err=1 and stays 1; lives unchanged; 5 read pulses -> attempts=5; resetn low mid-PLAYING -> immediate IDLE with all outputs 0.
